// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// operand mode encodings and the controller state enum.
package mult_pkg;

    localparam logic [1:0] MODE_UU = 2'b00;  // unsigned x unsigned
    localparam logic [1:0] MODE_SS = 2'b01;  // signed   x signed
    localparam logic [1:0] MODE_SU = 2'b10;  // signed a x unsigned b

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier with valid/ready on both sides.
// Operands are converted to sign + magnitude at accept, the magnitudes are
// multiplied one multiplier bit per clock, and the sign is re-applied when
// the result is registered. Result holds in DONE until out_ready.
//
// Build option MULT_ZERO_BYPASS_EN: a zero operand skips the iterations and
// the zero result is presented one edge after accept.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | WIDTH shift-add iterations, then one cycle to register the result
// DONE  | product valid, held until out_ready
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     bmag_q;
    logic                 neg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 out_valid_q;

    logic                 sa;
    logic                 sb;
    logic                 neg_d;
    logic [WIDTH-1:0]     amag_d;
    logic [WIDTH-1:0]     bmag_d;
    logic [WIDTH:0]       sum;
    logic                 accept;
    logic                 zero_op;

    // Handshake: DONE can hand off and accept on the same edge.
    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = (state_q != IDLE);

    // Operand sign/magnitude at accept and one shift-add step of the datapath.
    always_comb begin
        sa      = (mode == MODE_SS) || (mode == MODE_SU);
        sb      = (mode == MODE_SS);
        neg_d   = (sa & a[WIDTH-1]) ^ (sb & b[WIDTH-1]);
        // Most negative value negates to itself, which is the correct magnitude.
        amag_d  = (sa && a[WIDTH-1]) ? -a : a;
        bmag_d  = (sb && b[WIDTH-1]) ? -b : b;
        zero_op = (a == '0) || (b == '0);
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? bmag_q : {WIDTH{1'b0}})};
        acc_d   = {sum, acc_q[WIDTH-1:1]};
    end

    // Controller and datapath registers; an accept overrides the case result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            product_q   <= '0;
            bmag_q      <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                BUSY: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        product_q   <= neg_q ? -acc_q : acc_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                neg_q   <= neg_d;
                bmag_q  <= bmag_d;
                state_q <= BUSY;
`ifdef MULT_ZERO_BYPASS_EN
                // Zero operand: skip straight to the result-registering cycle.
                if (zero_op) begin
                    acc_q <= '0;
                    cnt_q <= CNT_W'(WIDTH);
                end else begin
                    acc_q <= {{WIDTH{1'b0}}, amag_d};
                    cnt_q <= '0;
                end
`else
                acc_q <= {{WIDTH{1'b0}}, amag_d};
                cnt_q <= '0;
`endif
            end
        end
    end

    // zero_op only steers the bypass build.
    logic unused_ok;
    assign unused_ok = zero_op;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=8 directed vectors plus a WIDTH=64
// instance driven with random operands against a wide signed product.
module tb_seq_multiplier;

    logic         clk;
    logic         reset;

    logic         in_valid;
    logic         in_ready;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  product;
    logic         busy;

    logic         in_valid64;
    logic         in_ready64;
    logic [63:0]  a64;
    logic [63:0]  b64;
    logic [1:0]   mode64;
    logic         out_valid64;
    logic         out_ready64;
    logic [127:0] product64;
    logic         busy64;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    seq_multiplier #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .mode(mode64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .product(product64), .busy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] mv);
        @(negedge clk);
        a = av; b = bv; mode = mv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; mode = 2'b11;
    endtask

    task automatic wait8(input string tag, input logic [15:0] exp, input int explat);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(explat));
        chk(tag, 128'(product), 128'(exp));
    endtask

    task automatic take8();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid after take", 128'(out_valid), 128'(0));
    endtask

    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [1:0] mv, input logic [15:0] exp);
        start8(av, bv, mv);
        wait8(tag, exp, 9);
        take8();
    endtask

    initial begin
        int zlat;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; a64 = '0; b64 = '0; mode64 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset product", 128'(product), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        reset = 1'b0;

        op8("SS FFxFF", 8'hFF, 8'hFF, 2'b01, 16'h0001);
        op8("SS 80x80", 8'h80, 8'h80, 2'b01, 16'h4000);
        op8("UU 80x80", 8'h80, 8'h80, 2'b00, 16'h4000);
        op8("SS 80x01", 8'h80, 8'h01, 2'b01, 16'hFF80);
        op8("UU FFxFF", 8'hFF, 8'hFF, 2'b00, 16'hFE01);
        op8("SU FFxFF", 8'hFF, 8'hFF, 2'b10, 16'hFF01);
        op8("M11 FFxFF", 8'hFF, 8'hFF, 2'b11, 16'hFE01);

        // Backpressure then same-edge accept
        start8(8'h0C, 8'h0D, 2'b00);
        chk("busy in BUSY", 128'(busy), 128'(1));
        chk("in_ready in BUSY", 128'(in_ready), 128'(0));
        wait8("bp UU 0Cx0D", 16'h009C, 9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp product hold", 128'(product), 128'(16'h009C));
            chk("bp out_valid hold", 128'(out_valid), 128'(1));
            chk("bp in_ready low", 128'(in_ready), 128'(0));
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        a = 8'h85; b = 8'h07; mode = 2'b01;
        #1;
        chk("b2b in_ready comb", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; mode = 2'b00;
        chk("b2b out_valid drop", 128'(out_valid), 128'(0));
        chk("b2b busy", 128'(busy), 128'(1));
        wait8("b2b SS 85x07", 16'hFCA3, 9);
        take8();

        // Reset at BUSY iteration 3
        start8(8'h12, 8'h34, 2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort out_valid", 128'(out_valid), 128'(0));
        chk("abort product", 128'(product), 128'(0));
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        reset = 1'b0;
        op8("post-reset UU 12x34", 8'h12, 8'h34, 2'b00, 16'h03A8);

        // Zero operand
`ifdef MULT_ZERO_BYPASS_EN
        zlat = 1;
`else
        zlat = 9;
`endif
        start8(8'h00, 8'h9C, 2'b01);
        wait8("SS 00x9C", 16'h0000, zlat);
        take8();
        start8(8'h9C, 8'h00, 2'b10);
        wait8("SU 9Cx00", 16'h0000, zlat);
        take8();

        // WIDTH=64 random operands against a wide signed product
        for (int k = 0; k < 150; k++) begin
            logic signed [127:0] ea, eb, ep;
            logic [63:0] ra, rb;
            logic [1:0]  rm;
            int n;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rm = 2'($urandom_range(0, 3));
            if (k == 0) begin ra = 64'h8000_0000_0000_0000; rb = 64'h8000_0000_0000_0000; rm = 2'b01; end
            if (k == 1) begin ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'hFFFF_FFFF_FFFF_FFFF; rm = 2'b10; end
            ea = (rm == 2'b01 || rm == 2'b10) ? {{64{ra[63]}}, ra} : {64'b0, ra};
            eb = (rm == 2'b01) ? {{64{rb[63]}}, rb} : {64'b0, rb};
            ep = ea * eb;
            @(negedge clk);
            a64 = ra; b64 = rb; mode64 = rm; in_valid64 = 1'b1;
            @(posedge clk);
            #1;
            in_valid64 = 1'b0;
            a64 = ~ra; b64 = ~rb;
            n = 0;
            while (!out_valid64 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("w64 latency", 128'(n), 128'(65));
            chk("w64 product", product64, ep);
            @(negedge clk);
            out_ready64 = 1'b1;
            @(posedge clk);
            #1;
            out_ready64 = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
